// File: rtl/uart_ctrl.sv
// Bus-side UART controller: TX/RX byte FIFOs, transmitter start/busy sequencing,
// and a DATA/STATUS/CTRL register file behind a single-ack bus handshake.
`timescale 1ns/1ps
module uart_ctrl #(
   parameter int FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bus_addr_i,
   input  logic [31:0] bus_data_i,
   output logic [31:0] bus_data_o,
   input  logic        bus_select_i,
   input  logic        bus_we_i,
   output logic        bus_ack_o,
   output logic        irq_o,
   output logic        tx_start_o,
   output logic [7:0]  tx_data_o,
   input  logic        tx_busy_i,
   input  logic        rx_ready_i,
   input  logic [7:0]  rx_data_i
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
   localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

   typedef enum logic [1:0] {B_IDLE, B_ACK, B_WAIT} bus_state_t;
   typedef enum logic [1:0] {T_IDLE, T_WBUSY, T_WDONE} tx_state_t;

   bus_state_t bus_state, bus_next;
   tx_state_t  tx_state, tx_next;

   logic [7:0]         tx_mem [DEPTH];
   logic [7:0]         rx_mem [DEPTH];
   logic [FIFO_AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
   logic [FIFO_AW:0]   tx_count, rx_count;

   logic rx_ie, tx_ie, rx_overrun, tx_overflow;
   logic access, wr_data_acc, rd_data_acc, rd_status_acc, wr_ctrl_acc;
   logic tx_full, tx_nempty, rx_full, rx_nempty, tx_idle;
   logic tx_pop, tx_push_ok, rx_pop, rx_push_ok;
   logic [4:0]  status;
   logic [31:0] rdata;
   logic [1:0]  reg_sel;
   logic        unused_bits;

   assign unused_bits = ^{bus_addr_i[31:4], bus_addr_i[1:0], bus_data_i[31:8]};

   assign reg_sel       = bus_addr_i[3:2];
   assign access        = (bus_state == B_IDLE) && bus_select_i;
   assign wr_data_acc   = access && bus_we_i && (reg_sel == 2'd0);
   assign rd_data_acc   = access && !bus_we_i && (reg_sel == 2'd0);
   assign rd_status_acc = access && !bus_we_i && (reg_sel == 2'd1);
   assign wr_ctrl_acc   = access && bus_we_i && (reg_sel == 2'd2);

   assign tx_full   = (tx_count == FULL_CNT);
   assign tx_nempty = (tx_count != '0);
   assign rx_full   = (rx_count == FULL_CNT);
   assign rx_nempty = (rx_count != '0);
   assign tx_idle   = !tx_nempty && (tx_state == T_IDLE) && !tx_busy_i;
   assign status    = {tx_overflow, rx_overrun, tx_idle, !tx_full, rx_nempty};

   // A pop in the same cycle frees the slot a push would otherwise overflow
   assign tx_push_ok = wr_data_acc && (!tx_full || tx_pop);
   assign rx_pop     = rd_data_acc && rx_nempty;
   assign rx_push_ok = rx_ready_i && (!rx_full || rx_pop);

   always_comb begin
      rdata = '0;
      if (!bus_we_i) begin
         case (reg_sel)
            2'd0: if (rx_nempty) rdata = {24'd0, rx_mem[rx_rd_ptr]};
            2'd1: rdata = {27'd0, status};
            2'd2: rdata = {30'd0, tx_ie, rx_ie};
            default: rdata = '0;
         endcase
      end
   end

   always_comb begin
      bus_next = bus_state;
      case (bus_state)
         B_IDLE:  if (bus_select_i) bus_next = B_ACK;
         B_ACK:   bus_next = B_WAIT;
         B_WAIT:  if (!bus_select_i) bus_next = B_IDLE;
         default: bus_next = B_IDLE;
      endcase
   end

   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      case (tx_state)
         T_IDLE: begin
            if (tx_nempty && !tx_busy_i) begin
               tx_pop  = 1'b1;
               tx_next = T_WBUSY;
            end
         end
         T_WBUSY: if (tx_busy_i) tx_next = T_WDONE;
         T_WDONE: if (!tx_busy_i) tx_next = T_IDLE;
         default: tx_next = T_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_state  <= B_IDLE;
         tx_state   <= T_IDLE;
         bus_ack_o  <= 1'b0;
         bus_data_o <= '0;
         tx_start_o <= 1'b0;
         tx_data_o  <= '0;
         irq_o      <= 1'b0;
      end else begin
         bus_state  <= bus_next;
         tx_state   <= tx_next;
         bus_ack_o  <= access;
         bus_data_o <= access ? rdata : '0;
         tx_start_o <= tx_pop;
         if (tx_pop) tx_data_o <= tx_mem[tx_rd_ptr];
         irq_o      <= (rx_ie && rx_nempty) || (tx_ie && tx_idle);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_ie       <= 1'b0;
         tx_ie       <= 1'b0;
         rx_overrun  <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         if (wr_ctrl_acc) begin
            rx_ie <= bus_data_i[0];
            tx_ie <= bus_data_i[1];
         end
         if (rd_status_acc) begin
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
         end
         // A new loss event outranks the read-clear in the same cycle
         if (rx_ready_i && !rx_push_ok) rx_overrun <= 1'b1;
         if (wr_data_acc && !tx_push_ok) tx_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
         if (tx_pop)     tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
         case ({tx_push_ok, tx_pop})
            2'b10:   tx_count <= tx_count + CNT_ONE;
            2'b01:   tx_count <= tx_count - CNT_ONE;
            default: tx_count <= tx_count;
         endcase
         if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
         if (rx_pop)     rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
         case ({rx_push_ok, rx_pop})
            2'b10:   rx_count <= rx_count + CNT_ONE;
            2'b01:   rx_count <= rx_count - CNT_ONE;
            default: rx_count <= rx_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push_ok) tx_mem[tx_wr_ptr] <= bus_data_i[7:0];
      if (rx_push_ok) rx_mem[rx_wr_ptr] <= rx_data_i;
   end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: register access, TX sequencing, RX buffering, irq and reset.
`timescale 1ns/1ps
module tb_uart_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bus_addr_i, bus_data_i, bus_data_o;
   logic        bus_select_i, bus_we_i, bus_ack_o, irq_o;
   logic        tx_start_o, tx_busy_i, rx_ready_i;
   logic [7:0]  tx_data_o, rx_data_i;

   logic        force_busy;
   int          busy_cnt;
   int          starts;
   logic [7:0]  cap[$];
   int          n_assert = 0;
   int          n_fail = 0;

   uart_ctrl #(.FIFO_AW(4)) dut (
      .clk(clk), .rst(rst),
      .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i), .bus_data_o(bus_data_o),
      .bus_select_i(bus_select_i), .bus_we_i(bus_we_i), .bus_ack_o(bus_ack_o),
      .irq_o(irq_o), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
      .tx_busy_i(tx_busy_i), .rx_ready_i(rx_ready_i), .rx_data_i(rx_data_i)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy for 10 cycles after each start pulse
   assign tx_busy_i = force_busy | (busy_cnt != 0);
   always @(posedge clk or negedge rst) begin
      if (!rst) busy_cnt <= 0;
      else if (tx_start_o) busy_cnt <= 10;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   always @(negedge clk) begin
      if (tx_start_o) begin
         starts = starts + 1;
         cap.push_back(tx_data_o);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called and returns at a negedge; bus FSM is back in B_IDLE on return
   task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] wd,
                      output logic [31:0] rd);
      logic got;
      got = 1'b0;
      rd = '0;
      bus_addr_i = {28'd0, a, 2'b00};
      bus_we_i = we;
      bus_data_i = wd;
      bus_select_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus_ack_o) begin
            got = 1'b1;
            rd = bus_data_o;
            break;
         end
      end
      bus_select_i = 1'b0;
      bus_we_i = 1'b0;
      check("bus_ack", {31'd0, got}, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      logic [31:0] dummy;
      bus(1'b1, a, {24'd0, d}, dummy);
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus(1'b0, a, 32'd0, v);
      check(tag, v, exp);
   endtask

   task automatic rx_pulse(input logic [7:0] d);
      rx_ready_i = 1'b1;
      rx_data_i = d;
      @(negedge clk);
      rx_ready_i = 1'b0;
   endtask

   initial begin
      int s0;
      int acks;
      logic [31:0] v;
      rst = 1'b0;
      bus_addr_i = '0; bus_data_i = '0; bus_select_i = 1'b0; bus_we_i = 1'b0;
      rx_ready_i = 1'b0; rx_data_i = '0; force_busy = 1'b0; starts = 0;
      repeat (3) @(negedge clk);
      check("rst_ack", {31'd0, bus_ack_o}, 32'd0);
      check("rst_data", bus_data_o, 32'd0);
      check("rst_outs", {22'd0, irq_o, tx_start_o, tx_data_o}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rd_chk("status_reset", 2'd1, 32'h06);

      // Two bytes through the transmitter
      wr(2'd0, 8'h41);
      wr(2'd0, 8'h42);
      repeat (50) @(negedge clk);
      check("tx_starts", starts, 2);
      check("tx_byte0", {24'd0, cap[0]}, 32'h41);
      check("tx_byte1", {24'd0, cap[1]}, 32'h42);
      rd_chk("status_tx_idle", 2'd1, 32'h06);

      // TX overflow with transmitter held busy
      force_busy = 1'b1;
      for (int i = 0; i < 17; i++) wr(2'd0, 8'h60 + 8'(i));
      rd_chk("status_overflow", 2'd1, 32'h10);
      rd_chk("status_ovf_clear", 2'd1, 32'h00);
      s0 = starts;
      force_busy = 1'b0;
      repeat (300) @(negedge clk);
      check("tx_drain_count", starts - s0, 16);
      check("tx_drain_first", {24'd0, cap[s0]}, 32'h60);
      check("tx_drain_last", {24'd0, cap[s0 + 15]}, 32'h6F);
      rd_chk("status_drained", 2'd1, 32'h06);

      // Basic RX
      rx_pulse(8'h55);
      rx_pulse(8'hAA);
      rd_chk("status_rx_nempty", 2'd1, 32'h07);
      rd_chk("rx_read0", 2'd0, 32'h55);
      rd_chk("rx_read1", 2'd0, 32'hAA);
      rd_chk("rx_read_empty", 2'd0, 32'h00);

      // RX overrun
      for (int i = 0; i < 17; i++) rx_pulse(8'h80 + 8'(i));
      rd_chk("status_overrun", 2'd1, 32'h0F);
      for (int i = 0; i < 16; i++) rd_chk("rx_full_order", 2'd0, 32'h80 + i);
      rd_chk("status_rx_empty", 2'd1, 32'h06);

      // 17th push coincident with a DATA read: accepted, no overrun
      for (int i = 0; i < 16; i++) rx_pulse(8'hC0 + 8'(i));
      bus_addr_i = 32'd0; bus_we_i = 1'b0; bus_select_i = 1'b1;
      rx_ready_i = 1'b1; rx_data_i = 8'hEE;
      @(posedge clk); #1;
      rx_ready_i = 1'b0;
      bus_select_i = 1'b0;
      check("coinc_ack", {31'd0, bus_ack_o}, 32'd1);
      check("coinc_data", bus_data_o, 32'hC0);
      repeat (3) @(negedge clk);
      rd_chk("status_no_overrun", 2'd1, 32'h07);
      for (int i = 1; i < 16; i++) rd_chk("rx_coinc_order", 2'd0, 32'hC0 + i);
      rd_chk("rx_coinc_last", 2'd0, 32'hEE);
      rd_chk("rx_coinc_empty", 2'd0, 32'h00);

      // Select held high for 5 cycles: one ack, one push
      force_busy = 1'b1;
      s0 = starts;
      acks = 0;
      bus_addr_i = 32'd0; bus_we_i = 1'b1; bus_data_i = 32'h33; bus_select_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (bus_ack_o) acks++;
      end
      bus_select_i = 1'b0; bus_we_i = 1'b0;
      repeat (3) @(negedge clk);
      check("held_select_acks", acks, 1);
      force_busy = 1'b0;
      repeat (40) @(negedge clk);
      check("held_select_pushes", starts - s0, 1);
      check("held_select_byte", {24'd0, cap[s0]}, 32'h33);

      // Interrupt on RX data
      wr(2'd2, 8'h01);
      check("irq_idle", {31'd0, irq_o}, 32'd0);
      rx_pulse(8'h77);
      @(posedge clk); #1;
      check("irq_rx_set", {31'd0, irq_o}, 32'd1);
      @(negedge clk);
      rd_chk("ctrl_read", 2'd2, 32'h01);
      rd_chk("irq_rx_data", 2'd0, 32'h77);
      check("irq_rx_clear", {31'd0, irq_o}, 32'd0);
      wr(2'd3, 8'hFF);
      rd_chk("reg3_read", 2'd3, 32'h00);

      // Reset in the middle of a transmission
      force_busy = 1'b1;
      wr(2'd0, 8'h99);
      wr(2'd0, 8'h9A);
      force_busy = 1'b0;
      v = 32'd0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (tx_start_o) begin
            v = 32'd1;
            break;
         end
      end
      check("start_before_reset", v, 32'd1);
      #2 rst = 1'b0;
      #1;
      check("async_start_low", {31'd0, tx_start_o}, 32'd0);
      check("async_outs", {22'd0, irq_o, bus_ack_o, tx_data_o}, 32'd0);
      check("async_bus_data", bus_data_o, 32'd0);
      s0 = starts;
      @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      check("queued_lost", starts - s0, 0);
      rd_chk("status_after_reset", 2'd1, 32'h06);
      rd_chk("ctrl_after_reset", 2'd2, 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
Bus-side controller for the UART transmitter/receiver drivers. It buffers outgoing and incoming bytes in FIFOs and sequences the transmitter's start/busy handshake. It captures receiver data-ready pulses and exposes data, status and control registers on the Wishbone-style bus, with a single-cycle ack per access and a level interrupt. It sits between the system bus decoder and the two driver instances, replacing their direct wiring.

Parameters:
FIFO_AW, 4, log2 of TX and RX FIFO depth (depth 16).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
bus_addr_i  in  32  byte address; only [3:2] are decoded.
bus_data_i  in  32  write data; [7:0] used.
bus_data_o  out  32  registered read data, valid while bus_ack_o=1.
bus_select_i  in  1  access request, held until ack.
bus_we_i  in  1  1=write, 0=read.
bus_ack_o  out  1  one-cycle access acknowledge.
irq_o  out  1  level interrupt.
tx_start_o  out  1  one-cycle start pulse to the transmitter.
tx_data_o  out  8  byte to the transmitter; stable from the start pulse until busy falls.
tx_busy_i  in  1  transmitter busy.
rx_ready_i  in  1  one-cycle receiver data-ready pulse.
rx_data_i  in  8  receiver byte, valid with rx_ready_i.

Behaviour:
- Reset (rst=0, async): both FIFOs empty; all control and sticky bits 0; TX FSM in T_IDLE; bus FSM in B_IDLE; every output 0.
- Register map, bus_addr_i[3:2]:
  - 0 DATA: write pushes [7:0] to the TX FIFO; read pops the RX FIFO and returns {24'b0, byte}.
  - 1 STATUS, read-only: bit0 rx_nempty; bit1 tx_nfull; bit2 tx_idle (TX FIFO empty and T_IDLE and !tx_busy_i); bit3 rx_overrun; bit4 tx_overflow. Bits [31:5] read 0. A STATUS read clears bits 3 and 4 in the ack cycle.
  - 2 CTRL, R/W: bit0 rx_ie; bit1 tx_ie.
  - 3: reads 0; writes are ignored.
- Bus FSM: B_IDLE -> B_ACK -> B_WAIT -> B_IDLE.
  - B_IDLE -> B_ACK when bus_select_i is sampled 1. The access takes effect on that edge.
  - B_ACK: bus_ack_o=1 for exactly one cycle; bus_data_o is held.
  - B_WAIT: return to B_IDLE once bus_select_i is sampled 0. No second ack while select stays high.
  - Latency: select sampled at edge N, ack high during cycle N+1. Outside B_ACK, bus_data_o=0.
- DATA write with the TX FIFO full: byte dropped, tx_overflow set, ack still given.
- DATA read with the RX FIFO empty: returns 0, no pop, ack given.
- RX path: rx_ready_i=1 pushes rx_data_i.
  - RX full with no pop that cycle: byte dropped, rx_overrun set.
  - RX full with a pop in the same cycle: the push is accepted and count stays 16.
- TX FSM:
  - T_IDLE: if TX FIFO is non-empty and tx_busy_i=0, pop the head into tx_data_o, drive tx_start_o=1 for one cycle, go to T_WBUSY.
  - T_WBUSY: wait for tx_busy_i=1, then go to T_WDONE.
  - T_WDONE: wait for tx_busy_i=0, then go to T_IDLE.
  - Minimum 2-cycle gap between start pulses.
  - A simultaneous bus push and TX pop on a full FIFO is accepted, with no overflow.
- FIFOs: circular buffers with FIFO_AW-bit pointers that wrap modulo depth, plus a (FIFO_AW+1)-bit count. Full = count==2^FIFO_AW; empty = count==0.
- irq_o is registered: irq_o = (rx_ie & rx_nempty) | (tx_ie & tx_idle).
- Reset mid-transfer: FSMs and FIFOs clear immediately. tx_start_o falls asynchronously. Queued bytes are lost.

Test Plan:
- Write DATA=0x41, then 0x42, with tx_busy_i modelled at 10 cycles per byte -> two tx_start_o pulses, tx_data_o 0x41 then 0x42; STATUS bit2 returns to 1 afterwards.
- Write 17 bytes with tx_busy_i held 1 -> 16 queued; STATUS reads 0x10 (tx_overflow=1, tx_nfull=0); a second STATUS read shows bit4 cleared.
- Pulse rx_ready_i with 0x55 then 0xAA -> STATUS bit0=1; DATA reads return 0x55, then 0xAA, then 0x00.
- Push 17 RX bytes with no reads -> STATUS bit3=1, and the 16 stored bytes read back in order. Repeat with the 17th push coincident with a DATA read -> no overrun.
- Hold bus_select_i high for 5 cycles on a DATA write -> exactly one ack and one push. Set CTRL=0x1 and pulse rx_ready_i -> irq_o=1 two cycles later; drain RX -> irq_o=0.
- Assert rst=0 mid-transmission -> all outputs 0 within the same cycle; STATUS after release reads 0x06.
